// File: rtl/interval_timer_pkg.sv
// Shared register map, CTRL bit positions and reset reload value for interval_timer.
package interval_timer_pkg;

  localparam logic [1:0] TMR_CTRL = 2'd0;
  localparam logic [1:0] TMR_LO   = 2'd1;
  localparam logic [1:0] TMR_HI   = 2'd2;
  localparam logic [1:0] TMR_STAT = 2'd3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int CTRL_ONESHOT = 2;

  // 625 ticks of the 625 kHz strobe = 1 ms system tick
  localparam int RELOAD_RST_DEF = 624;

endpackage

// File: rtl/interval_timer_edge_pulse.sv
// One-flop rising-edge detector: pulse is high for the single cycle where din is
// first seen high.
module edge_pulse (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b0;
    else        prev <= din;
  end

  assign pulse = din & ~prev;

endmodule

// File: rtl/interval_timer.sv
// Programmable periodic/one-shot interval timer on the Z80 I/O bus, counting
// tim_clk rising edges as an enable in the clock_in domain.
module interval_timer
  import interval_timer_pkg::*;
#(
  parameter int COUNT_W    = 16,
  parameter int RELOAD_RST = RELOAD_RST_DEF
) (
  input  logic       clock_in,
  input  logic       reset_n,
  input  logic       tim_clk,
  input  logic       cs,
  input  logic       wr,
  input  logic       rd,
  input  logic [1:0] addr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       int_n
);

  if (COUNT_W < 9 || COUNT_W > 16) begin : g_bad_width
    $error("interval_timer: COUNT_W must be 9..16");
  end

  logic tick, wr_stb, rd_stb;

  edge_pulse u_tick (.clk(clock_in), .rst_n(reset_n), .din(tim_clk),   .pulse(tick));
  edge_pulse u_wr   (.clk(clock_in), .rst_n(reset_n), .din(cs & wr),   .pulse(wr_stb));
  edge_pulse u_rd   (.clk(clock_in), .rst_n(reset_n), .din(cs & rd),   .pulse(rd_stb));

  logic               en, irq_en, oneshot, flag;
  logic [COUNT_W-1:0] count, reload;
  logic [7:0]         hi_shadow;
  logic [15:0]        cnt16;

  logic wr_ctrl, wr_lo, wr_hi, wr_stat, run_tick, expire;

  assign cnt16   = 16'(count);
  assign wr_ctrl = wr_stb && (addr == TMR_CTRL);
  assign wr_lo   = wr_stb && (addr == TMR_LO);
  assign wr_hi   = wr_stb && (addr == TMR_HI);
  assign wr_stat = wr_stb && (addr == TMR_STAT);

  // A CTRL write that clears EN beats a coincident tick
  assign run_tick = en && tick && !(wr_ctrl && !data_in[CTRL_EN]);
  assign expire   = run_tick && (count == '0);

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      en      <= 1'b0;
      irq_en  <= 1'b0;
      oneshot <= 1'b0;
      count   <= '0;
      reload  <= COUNT_W'(RELOAD_RST);
    end else begin
      if (wr_lo) reload[7:0]         <= data_in;
      if (wr_hi) reload[COUNT_W-1:8] <= data_in[COUNT_W-9:0];
      if (wr_ctrl) begin
        en      <= data_in[CTRL_EN];
        irq_en  <= data_in[CTRL_IRQ_EN];
        oneshot <= data_in[CTRL_ONESHOT];
        if (data_in[CTRL_EN] && !en) count <= reload;
      end
      if (run_tick) begin
        if (count != '0)  count <= count - COUNT_W'(1);
        else if (oneshot) en    <= 1'b0;
        else              count <= reload;
      end
    end
  end

  // Expiry has priority over a coincident STATUS clear
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      flag  <= 1'b0;
      int_n <= 1'b1;
    end else begin
      if (expire)                     flag <= 1'b1;
      else if (wr_stat && data_in[0]) flag <= 1'b0;
      int_n <= ~(flag & irq_en);
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      data_out  <= 8'h00;
      hi_shadow <= 8'h00;
    end else if (rd_stb) begin
      unique case (addr)
        TMR_CTRL: data_out <= {5'b0, oneshot, irq_en, en};
        TMR_LO: begin
          data_out  <= cnt16[7:0];
          hi_shadow <= cnt16[15:8];
        end
        TMR_HI:   data_out <= hi_shadow;
        default:  data_out <= {6'b0, en, flag};
      endcase
    end
  end

endmodule
